// File: rtl/mem_access_ctrl.sv
// Single-port request/response controller in front of a synchronous memory.
// Writes take one strobe cycle; reads strobe, wait one cycle for data, then hold a response.
module mem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [7:0]            wr_count,
    output logic [7:0]            rd_count
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [7:0]              wr_count_q, wr_count_d;
    logic [7:0]              rd_count_q, rd_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    // The request direction is carried by the WRITE/READ state, so no separate we flop.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? StWrite : StRead;
                end
            end
            StWrite: begin
                wr_count_d = wr_count_q + 8'd1;
                state_d    = StIdle;
            end
            StRead: begin
                state_d = StWait;
            end
            StWait: begin
                rdata_d = mem_rdata;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rd_count_d = rd_count_q + 8'd1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // req_ready is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        req_ready = rst_n && (state_q == StIdle);
        mem_write = (state_q == StWrite);
        mem_read  = (state_q == StRead);
        mem_addr  = (mem_write || mem_read) ? addr_q : '0;
        mem_wdata = mem_write ? wdata_q : '0;
        rsp_valid = (state_q == StResp);
        rsp_rdata = rdata_q;
        wr_count  = wr_count_q;
        rd_count  = rd_count_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table, directed corner sequences and a random mix
// checked against an array scoreboard and a protocol monitor.
module tb_mem_access_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] wr_count;
    logic [7:0] rd_count;

    mem_access_ctrl #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wr_count  (wr_count),
        .rd_count  (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream synchronous memory.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol monitor: strobe overlap, strobe length, idle bus values, pulse counts.
    int   viol = 0;
    int   n_wr_pulses = 0;
    int   n_rd_pulses = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read && mem_write) viol++;
            if ((mem_read && prev_rd) || (mem_write && prev_wr)) viol++;
            if (!mem_read && !mem_write && (mem_addr != 5'd0 || mem_wdata != 8'd0)) viol++;
            if (mem_write) n_wr_pulses++;
            if (mem_read) n_rd_pulses++;
            prev_rd = mem_read;
            prev_wr = mem_write;
        end else begin
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [32];
    logic [7:0] exp_wr;
    logic [7:0] exp_rd;
    time        last_accept_t;

    // Called just after a rising edge; returns just after a rising edge with the DUT idle.
    task automatic do_txn(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input int rsp_delay, input logic keep);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        last_accept_t = $time;
        #1;
        if (!keep) req_valid = 1'b0;
        if (we) begin
            rsp_ready = 1'($urandom);
            @(negedge clk);
            check("wr_strobe", {mem_read, mem_write, req_ready}, 32'b010);
            check("wr_addr", 32'(mem_addr), 32'(addr));
            check("wr_data", 32'(mem_wdata), 32'(wdata));
            @(posedge clk);
            #1;
        end else begin
            rsp_ready = (rsp_delay == 0);
            @(negedge clk);
            check("rd_strobe", {mem_read, mem_write, rsp_valid}, 32'b100);
            check("rd_addr", 32'(mem_addr), 32'(addr));
            @(negedge clk);
            check("wait_quiet", {mem_read, mem_write, rsp_valid}, 32'b000);
            @(negedge clk);
            check("rsp_valid_lat3", {rsp_valid, req_ready}, 32'b10);
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            for (int i = 0; i < rsp_delay; i++) begin
                @(negedge clk);
                check("rsp_hold", {rsp_valid, req_ready, mem_read, mem_write}, 32'b1000);
                check("rsp_stable", 32'(rsp_rdata), 32'(exp_rdata));
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            check("rsp_done", {rsp_valid, req_ready}, 32'b01);
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [7:0] exp_wr;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0;
        int   r0;
        time  t_prev;
        logic we;
        logic [4:0] a;
        logic [7:0] d;
        logic keep;

        vecs[0] = '{1'b1, 5'd5,  8'hA5, 8'h00, 8'd1, 8'd0};
        vecs[1] = '{1'b0, 5'd5,  8'h00, 8'hA5, 8'd1, 8'd1};
        vecs[2] = '{1'b1, 5'd0,  8'h00, 8'h00, 8'd2, 8'd1};
        vecs[3] = '{1'b1, 5'd31, 8'hFF, 8'h00, 8'd3, 8'd1};
        vecs[4] = '{1'b0, 5'd31, 8'h00, 8'hFF, 8'd3, 8'd2};
        vecs[5] = '{1'b0, 5'd0,  8'h00, 8'h00, 8'd3, 8'd3};
        vecs[6] = '{1'b1, 5'd5,  8'h5A, 8'h00, 8'd4, 8'd3};
        vecs[7] = '{1'b0, 5'd5,  8'h00, 8'h5A, 8'd4, 8'd4};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        last_accept_t = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outputs", {req_ready, rsp_valid, mem_read, mem_write}, 32'd0);
        check("rst_bus", {mem_addr, mem_wdata, rsp_rdata}, 32'd0);
        check("rst_counts", {wr_count, rd_count}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_wr = 8'd0;
        exp_rd = 8'd0;

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            p0 = n_wr_pulses;
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 0, 1'b0);
            check("vec_wr_count", 32'(wr_count), 32'(vecs[i].exp_wr));
            check("vec_rd_count", 32'(rd_count), 32'(vecs[i].exp_rd));
            check("vec_wr_pulses", 32'(n_wr_pulses - p0), 32'(vecs[i].we));
            if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wdata;
            exp_wr = vecs[i].exp_wr;
            exp_rd = vecs[i].exp_rd;
        end

        // Back-to-back writes with req_valid held.
        p0 = n_wr_pulses;
        t_prev = 0;
        for (int i = 0; i < 32; i++) begin
            d = 8'(i) ^ 8'h3C;
            do_txn(1'b1, 5'(i), d, 8'h00, 0, (i != 31));
            ref_mem[i] = d;
            exp_wr = exp_wr + 8'd1;
            if (i > 0) check("b2b_spacing", 32'((last_accept_t - t_prev) / 10), 32'd2);
            t_prev = last_accept_t;
        end
        check("b2b_pulses", 32'(n_wr_pulses - p0), 32'd32);
        check("b2b_wr_count", 32'(wr_count), 32'(exp_wr));
        for (int i = 0; i < 32; i++) begin
            do_txn(1'b0, 5'(i), 8'h00, ref_mem[i], 0, 1'b0);
            exp_rd = exp_rd + 8'd1;
        end
        check("b2b_rd_count", 32'(rd_count), 32'(exp_rd));

        // Response backpressure.
        r0 = n_rd_pulses;
        p0 = n_wr_pulses;
        do_txn(1'b0, 5'd31, 8'h00, ref_mem[31], 10, 1'b0);
        exp_rd = exp_rd + 8'd1;
        check("bp_rd_count", 32'(rd_count), 32'(exp_rd));
        check("bp_strobes", 32'((n_rd_pulses - r0) + (n_wr_pulses - p0)), 32'd1);

        // Reset during WAIT.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd7;
        @(negedge clk);
        check("mid_rst_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {req_ready, rsp_valid, mem_read, mem_write}, 32'd0);
        check("mid_rst_bus", {mem_addr, mem_wdata, rsp_rdata}, 32'd0);
        check("mid_rst_counts", {wr_count, rd_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst", {req_ready, rsp_valid}, 32'b10);
        check("post_rst_counts", {wr_count, rd_count}, 32'd0);
        @(posedge clk);
        #1;
        exp_wr = 8'd0;
        exp_rd = 8'd0;

        // Counter wrap: 256 writes from zero, then one more.
        for (int i = 0; i < 256; i++) begin
            a = 5'($urandom);
            d = 8'($urandom);
            do_txn(1'b1, a, d, 8'h00, 0, 1'b0);
            ref_mem[a] = d;
            if (i == 0) check("post_rst_write", 32'(wr_count), 32'd1);
        end
        check("wrap_zero", 32'(wr_count), 32'd0);
        a = 5'($urandom);
        d = 8'($urandom);
        do_txn(1'b1, a, d, 8'h00, 0, 1'b0);
        ref_mem[a] = d;
        check("wrap_one", 32'(wr_count), 32'd1);
        exp_wr = 8'd1;

        // Random mix against the scoreboard.
        for (int i = 0; i < 1000; i++) begin
            we   = 1'($urandom);
            a    = 5'($urandom);
            d    = 8'($urandom);
            keep = ($urandom_range(0, 3) == 0);
            do_txn(we, a, d, ref_mem[a], ($urandom_range(0, 3) == 0) ? 2 : 0, keep);
            if (we) begin
                ref_mem[a] = d;
                exp_wr = exp_wr + 8'd1;
            end else begin
                exp_rd = exp_rd + 8'd1;
            end
            check("rand_counts", {wr_count, rd_count}, {16'd0, exp_wr, exp_rd});
            if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("monitor_violations", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
